// File: rtl/wbu_outarb.sv
// Two-channel round-robin output arbiter feeding the 36-bit deword stage.
// Optional keep-alive word generation is enabled by defining WBU_OUTARB_IDLE_EN.
module wbu_outarb #(
  parameter logic [25:0] IDLE_CYCLES = 26'd50000000,
  parameter logic [35:0] IDLE_WORD   = 36'h0
) (
  input  logic        i_clk,
  input  logic        i_areset_n,
  input  logic        i_stb0,
  input  logic [35:0] i_word0,
  output logic        o_busy0,
  input  logic        i_stb1,
  input  logic [35:0] i_word1,
  output logic        o_busy1,
  output logic        o_stb,
  output logic [35:0] o_word,
  input  logic        i_busy
);

  localparam int unsigned WORD_W = 36;
  localparam int unsigned CNT_W  = 26;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_hold0;
  logic [WORD_W-1:0] r_hold1;
  logic [WORD_W-1:0] r_word;
  logic              r_busy0;
  logic              r_busy1;
  logic              r_last_grant;

  logic              w_xfer;
  logic              w_free;
  logic              w_cap0;
  logic              w_cap1;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_grant;
  logic              w_load;
  logic [WORD_W-1:0] w_next_word;

  assign o_stb   = (r_state == S_FULL);
  assign o_word  = r_word;
  assign o_busy0 = r_busy0;
  assign o_busy1 = r_busy1;

  assign w_xfer = (r_state == S_FULL) & ~i_busy;
  assign w_free = (r_state == S_EMPTY) | w_xfer;
  assign w_cap0 = i_stb0 & ~r_busy0;
  assign w_cap1 = i_stb1 & ~r_busy1;

  // On a tie the channel that lost the previous grant wins
  assign w_grant1 = w_free & r_busy1 & (~r_busy0 | ~r_last_grant);
  assign w_grant0 = w_free & r_busy0 & ~w_grant1;
  assign w_grant  = w_grant0 | w_grant1;

`ifdef WBU_OUTARB_IDLE_EN
  logic [CNT_W-1:0] r_idle_cnt;
  logic             w_idle_fire;

  // Keep-alive only when nothing is held and no strobe is arriving this edge
  assign w_idle_fire = w_free & ~r_busy0 & ~r_busy1 & ~i_stb0 & ~i_stb1 &
                       (r_idle_cnt == (IDLE_CYCLES - CNT_W'(1)));
  assign w_load      = w_grant | w_idle_fire;
  assign w_next_word = w_grant1 ? r_hold1 : (w_grant0 ? r_hold0 : IDLE_WORD);

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_idle_cnt <= '0;
    end else if (w_cap0 | w_cap1 | w_xfer | w_idle_fire) begin
      r_idle_cnt <= '0;
    end else if ((r_state == S_EMPTY) & ~r_busy0 & ~r_busy1) begin
      r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{IDLE_CYCLES, IDLE_WORD};
  assign w_load       = w_grant;
  assign w_next_word  = w_grant1 ? r_hold1 : r_hold0;
`endif

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state      <= S_EMPTY;
      r_word       <= '0;
      r_hold0      <= '0;
      r_hold1      <= '0;
      r_busy0      <= 1'b0;
      r_busy1      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      // Holding registers: release on grant, otherwise capture when empty
      if (w_grant0) begin
        r_busy0 <= 1'b0;
      end else if (w_cap0) begin
        r_busy0 <= 1'b1;
        r_hold0 <= i_word0;
      end

      if (w_grant1) begin
        r_busy1 <= 1'b0;
      end else if (w_cap1) begin
        r_busy1 <= 1'b1;
        r_hold1 <= i_word1;
      end

      if (w_grant) begin
        r_last_grant <= w_grant1;
      end

      if (r_state == S_EMPTY) begin
        if (w_load) begin
          r_state <= S_FULL;
          r_word  <= w_next_word;
        end
      end else if (w_xfer) begin
        if (w_load) begin
          r_word <= w_next_word;
        end else begin
          r_state <= S_EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_wbu_outarb.sv
// Scoreboard bench for wbu_outarb: directed grant/backpressure/reset cases and a random stream.
// The keep-alive section runs only when WBU_OUTARB_IDLE_EN is defined.
module tb_wbu_outarb;

  localparam logic [35:0] T_IDLE_WORD = 36'hF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        stb0;
  logic        stb1;
  logic [35:0] word0;
  logic [35:0] word1;
  logic        busy0;
  logic        busy1;
  logic        ostb;
  logic [35:0] oword;
  logic        busy_in;

  int          n_checks;
  int          n_errors;
  int          n_del0;
  int          n_del1;
  bit          stream_mode;
  bit          idle_tolerant;
  logic [35:0] q_dir[$];
  logic [35:0] q_ch0[$];
  logic [35:0] q_ch1[$];

  wbu_outarb #(
    .IDLE_CYCLES(26'd8),
    .IDLE_WORD  (T_IDLE_WORD)
  ) u_dut (
    .i_clk     (clk),
    .i_areset_n(rst_n),
    .i_stb0    (stb0),
    .i_word0   (word0),
    .o_busy0   (busy0),
    .i_stb1    (stb1),
    .i_word1   (word1),
    .o_busy1   (busy1),
    .o_stb     (ostb),
    .o_word    (oword),
    .i_busy    (busy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: a transfer happens at the next rising edge when o_stb=1 and i_busy=0
  always @(negedge clk) begin
    if (rst_n && ostb && !busy_in) begin
      if (idle_tolerant && oword == T_IDLE_WORD) begin
        n_checks = n_checks;
      end else if (stream_mode) begin
        if (oword[35]) begin
          if (q_ch1.size() > 0) begin
            check("ch1_order", oword, q_ch1.pop_front());
            n_del1++;
          end else check("ch1_extra", 36'(q_ch1.size()), 36'd1);
        end else begin
          if (q_ch0.size() > 0) begin
            check("ch0_order", oword, q_ch0.pop_front());
            n_del0++;
          end else check("ch0_extra", 36'(q_ch0.size()), 36'd1);
        end
      end else begin
        if (q_dir.size() > 0) check("out_word", oword, q_dir.pop_front());
        else check("unexpected_xfer", 36'(q_dir.size()), 36'd1);
      end
    end
  end

  initial begin
    int sent0;
    int sent1;
    int cyc;
    rst_n = 1'b0; stb0 = 1'b0; stb1 = 1'b0; word0 = '0; word1 = '0; busy_in = 1'b0;
    n_checks = 0; n_errors = 0; n_del0 = 0; n_del1 = 0;
    stream_mode = 1'b0; idle_tolerant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stb", 36'(ostb), 36'd0);
    check("rst_busy0", 36'(busy0), 36'd0);
    check("rst_busy1", 36'(busy1), 36'd0);
    check("rst_word", oword, 36'h0);
    rst_n = 1'b1;

`ifdef WBU_OUTARB_IDLE_EN
    // Keep-alive cadence: 8 quiet edges, then one transfer edge
    q_dir.push_back(T_IDLE_WORD);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("idle_quiet", 36'(ostb), 36'd0);
    end
    tick();
    check("idle_stb", 36'(ostb), 36'd1);
    check("idle_word", oword, T_IDLE_WORD);
    q_dir.push_back(T_IDLE_WORD);
    tick();
    check("idle_xfer", 36'(ostb), 36'd0);
    repeat (7) tick();
    check("idle_quiet2", 36'(ostb), 36'd0);
    tick();
    check("idle_stb2", 36'(ostb), 36'd1);
    check("idle_word2", oword, T_IDLE_WORD);
    tick();
    repeat (7) tick();
    stb0 = 1'b1; word0 = 36'h0_0000_0777; q_dir.push_back(36'h0_0000_0777);
    tick();
    stb0 = 1'b0;
    check("idle_suppressed", 36'(ostb), 36'd0);
    tick();
    check("idle_chan_stb", 36'(ostb), 36'd1);
    check("idle_chan_word", oword, 36'h0_0000_0777);
    tick();
    idle_tolerant = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif

    // First tie after reset: channel 0 wins
    stb0 = 1'b1; word0 = 36'h1; stb1 = 1'b1; word1 = 36'h2;
    q_dir.push_back(36'h1); q_dir.push_back(36'h2);
    tick();
    stb0 = 1'b0; stb1 = 1'b0;
    check("tie1_busy0", 36'(busy0), 36'd1);
    check("tie1_busy1", 36'(busy1), 36'd1);
    tick();
    check("tie1_first", oword, 36'h1);
    check("tie1_busy0_rel", 36'(busy0), 36'd0);
    tick();
    check("tie1_second", oword, 36'h2);
    tick();
    check("tie1_done", 36'(ostb), 36'd0);

    // Single word on channel 0 (leaves channel 0 as last winner)
    stb0 = 1'b1; word0 = 36'h2_1234_5678; q_dir.push_back(36'h2_1234_5678);
    tick();
    stb0 = 1'b0;
    check("single_busy0", 36'(busy0), 36'd1);
    check("single_stb_pre", 36'(ostb), 36'd0);
    tick();
    check("single_stb", 36'(ostb), 36'd1);
    check("single_word", oword, 36'h2_1234_5678);
    check("single_busy0_rel", 36'(busy0), 36'd0);
    tick();
    check("single_done", 36'(ostb), 36'd0);

    // Second tie: channel 1 wins since channel 0 won last
    stb0 = 1'b1; word0 = 36'h3; stb1 = 1'b1; word1 = 36'h4;
    q_dir.push_back(36'h4); q_dir.push_back(36'h3);
    tick();
    stb0 = 1'b0; stb1 = 1'b0;
    tick();
    check("tie2_first", oword, 36'h4);
    tick();
    check("tie2_second", oword, 36'h3);
    tick();

    // Backpressure with refill of channel 0
    busy_in = 1'b1;
    stb0 = 1'b1; word0 = 36'hA_AAAA_0001;
    q_dir.push_back(36'hA_AAAA_0001); q_dir.push_back(36'hB_BBBB_0002);
    tick();
    stb0 = 1'b0;
    tick();
    stb0 = 1'b1; word0 = 36'hB_BBBB_0002;
    tick();
    stb0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_word", oword, 36'hA_AAAA_0001);
      check("bp_busy0", 36'(busy0), 36'd1);
      tick();
    end
    busy_in = 1'b0;
    tick();
    check("bp_next", oword, 36'hB_BBBB_0002);
    tick();
    check("bp_empty", 36'(ostb), 36'd0);
    check("bp_drain", 36'(q_dir.size()), 36'd0);

    // Asynchronous reset with output and both channels full
    busy_in = 1'b1;
    stb0 = 1'b1; word0 = 36'h0_DEAD_0001;
    tick();
    stb0 = 1'b0;
    tick();
    stb0 = 1'b1; word0 = 36'h0_DEAD_0002; stb1 = 1'b1; word1 = 36'h0_DEAD_0003;
    tick();
    stb0 = 1'b0; stb1 = 1'b0;
    check("pre_rst_full", 36'({ostb, busy0, busy1}), 36'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stb", 36'(ostb), 36'd0);
    check("arst_busy0", 36'(busy0), 36'd0);
    check("arst_busy1", 36'(busy1), 36'd0);
    check("arst_word", oword, 36'h0);
    q_dir.delete();
    tick();
    rst_n = 1'b1; busy_in = 1'b0;
    stb0 = 1'b1; word0 = 36'h5; stb1 = 1'b1; word1 = 36'h6;
    q_dir.push_back(36'h5); q_dir.push_back(36'h6);
    tick();
    stb0 = 1'b0; stb1 = 1'b0;
    tick();
    check("post_rst_first", oword, 36'h5);
    tick();
    check("post_rst_second", oword, 36'h6);
    tick();
    check("post_rst_drain", 36'(q_dir.size()), 36'd0);

    // Random stream, channel tag in bit 35
    stream_mode = 1'b1;
    sent0 = 0; sent1 = 0; cyc = 0;
    while ((sent0 < 1000 || sent1 < 1000) && cyc < 20000) begin
      busy_in = ($urandom_range(3) == 0);
      stb0 = 1'b0; stb1 = 1'b0;
      if (sent0 < 1000 && $urandom_range(1) == 1) begin
        stb0 = 1'b1; word0 = {4'h0, 32'($urandom)};
        if (!busy0) begin q_ch0.push_back(word0); sent0++; end
      end
      if (sent1 < 1000 && $urandom_range(1) == 1) begin
        stb1 = 1'b1; word1 = {4'h8, 32'($urandom)};
        if (!busy1) begin q_ch1.push_back(word1); sent1++; end
      end
      tick();
      cyc++;
    end
    stb0 = 1'b0; stb1 = 1'b0; busy_in = 1'b0;
    cyc = 0;
    while ((q_ch0.size() > 0 || q_ch1.size() > 0 || ostb) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("stream_sent0", 36'(sent0), 36'd1000);
    check("stream_sent1", 36'(sent1), 36'd1000);
    check("stream_del0", 36'(n_del0), 36'd1000);
    check("stream_del1", 36'(n_del1), 36'd1000);
    check("stream_left", 36'(q_ch0.size() + q_ch1.size()), 36'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wbu_outarb.md
WBU_OUTARB -- requirements
Module: wbu_outarb

Interface
REQ-001 Parameter IDLE_CYCLES, default 26'd50000000, sets the number of quiet cycles before a keep-alive word is sent (only with WBU_OUTARB_IDLE_EN).
REQ-002 Parameter IDLE_WORD, default 36'h0, is the keep-alive word value (only with WBU_OUTARB_IDLE_EN).
REQ-003 Port i_clk, input, 1 bit: sole clock; every register samples on its rising edge.
REQ-004 Port i_areset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Ports i_stb0 (input, 1) and i_word0 (input, 36): channel 0 (bus-return words) request strobe and data word.
REQ-006 Port o_busy0, output, 1 bit: channel 0 holding register is full.
REQ-007 Ports i_stb1 (input, 1) and i_word1 (input, 36): channel 1 (interrupt/status words) request strobe and data word.
REQ-008 Port o_busy1, output, 1 bit: channel 1 holding register is full.
REQ-009 Ports o_stb (output, 1) and o_word (output, 36): word offered to the downstream 36-to-6-bit deword stage.
REQ-010 Port i_busy, input, 1 bit: the downstream stage cannot accept a word.

Function
REQ-011 Each channel n SHALL capture i_wordn into its holding register, and set o_busyn, on the edge where i_stbn=1 and o_busyn=0; i_stbn while o_busyn=1 is ignored.
REQ-012 o_busyn SHALL be registered: it is 1 exactly while holding register n is full, so no refill can occur in the cycle the register is released.
REQ-013 An output transfer SHALL occur on any edge where o_stb=1 and i_busy=0; o_stb and o_word SHALL stay stable until that transfer.
REQ-014 The output register is free when o_stb=0, or when a transfer occurs on the same edge.
REQ-015 When the output register is free and at least one holding register is full, the arbiter SHALL load o_word from the granted channel, set o_stb=1, and clear that channel's holding register (o_busyn=0 on the next cycle), all on one edge.
REQ-016 Grant: with one full channel, grant it; with both full, grant the channel that did not win the previous grant (round-robin); update last_grant on every grant.
REQ-017 Latency: a word captured at edge k SHALL appear on o_stb at edge k+1 when the output is free and the channel wins; back-to-back words SHALL be sustainable at one per cycle while i_busy=0.
REQ-018 State machine: EMPTY (o_stb=0) and FULL (o_stb=1). EMPTY goes to FULL on a grant. FULL stays FULL on a transfer with a new grant, or when no transfer occurs. FULL goes to EMPTY on a transfer with no pending word.
REQ-019 Words from each channel SHALL be delivered in order, with none lost or duplicated.

Reset
REQ-020 Asserting i_areset_n=0 SHALL immediately force o_stb=0, o_busy0=0, o_busy1=0, both holding registers empty, last_grant=1 (channel 0 wins the first tie), idle counter=0, and o_word=36'h0.
REQ-021 Reset mid-transfer SHALL discard all pending words; the first accepted strobe after release SHALL be handled as from a fresh start.

Configuration
REQ-022 With macro WBU_OUTARB_IDLE_EN defined, a counter SHALL increment every cycle in which o_stb=0 and both holding registers are empty.
REQ-023 The counter SHALL clear on any input capture or output transfer.
REQ-024 When the counter reaches IDLE_CYCLES-1 with the output free and no holding register full, the block SHALL assert o_stb with o_word=IDLE_WORD on the next edge and clear the counter.
REQ-025 A pending channel word SHALL always take precedence over the idle word.
REQ-026 Without WBU_OUTARB_IDLE_EN, the block SHALL contain no idle counter and SHALL never emit a word that did not come from a channel.

Verification
REQ-027 Single word: pulse i_stb0 with i_word0=36'h2_1234_5678 and hold i_busy=0 -> o_stb=1 with o_word=36'h2_1234_5678 one cycle after capture; o_busy0 high for 1 cycle.
REQ-028 Tie: load both channels (ch0=36'h1, ch1=36'h2) on the same edge with i_busy=0 -> output order 1,2; repeat with ch0=36'h3, ch1=36'h4 -> output order 4,3.
REQ-029 Backpressure: hold i_busy=1 for 10 cycles with o_stb=1 -> o_word unchanged and o_busy0 stays 1 if refilled; release i_busy -> exactly one transfer per word.
REQ-030 Reset: assert i_areset_n=0 while o_stb=1 and both channels full -> all outputs 0 immediately, no stale word after release.
REQ-031 Idle (macro on, IDLE_CYCLES=8): no traffic -> o_stb=1 with IDLE_WORD every 8 cycles plus transfer time; a strobe on cycle 7 -> channel word delivered, no idle word emitted.
REQ-032 Stream: 1000 random words on each channel with random i_busy -> per-channel order preserved and the word count matches.
